dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
Sits between the pipeline MEM stage and the word-addressed data memory (async read, write on posedge clk). It shares the single memory port between the CPU and a loader/debug port using valid/ready. After reset it runs a clear engine that zero-fills the whole memory window before any access is granted. It also bounds-checks every access against the memory window.

Parameters:
ADDRESS_WIDTH, 32, width of all word-index address buses
DATA_WIDTH, 32, data word width
MEM_BASE, 32'h1000, lowest valid word index
MEM_TOP, 32'h1FFF, highest valid word index
CLEAR_ON_RESET, 1, 1 = zero-fill the memory after reset; 0 = go directly to RUN
STARVE_LIMIT, 8, number of consecutive CPU-won cycles after which a waiting loader is forced a grant (valid range 1..255)

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
cpu_req  input  1  CPU MEM stage performs a load or store this cycle
cpu_we  input  1  CPU store enable; qualified by cpu_req
cpu_a  input  ADDRESS_WIDTH  CPU word index
cpu_wd  input  DATA_WIDTH  CPU store data
cpu_rd  output  DATA_WIDTH  CPU load data, combinational
cpu_stall  output  1  CPU access not performed this cycle; the pipeline holds MEM
ldr_valid  input  1  loader request valid
ldr_we  input  1  loader write (1) or read (0)
ldr_a  input  ADDRESS_WIDTH  loader word index
ldr_wd  input  DATA_WIDTH  loader write data
ldr_ready  output  1  loader request accepted this cycle
ldr_rd  output  DATA_WIDTH  loader read data, registered
ldr_rvalid  output  1  ldr_rd is valid (1-cycle pulse)
mem_we  output  1  to memory WE
mem_a  output  ADDRESS_WIDTH  to memory A
mem_wd  output  DATA_WIDTH  to memory WD
mem_rd  input  DATA_WIDTH  from memory RD
init_done  output  1  high once the clear engine has finished
fault  output  1  registered 1-cycle pulse: the previous granted access was out of range

Behaviour:
- Reset (rst_n low at posedge) values:
  - state = CLEAR if CLEAR_ON_RESET=1, else RUN.
  - clr_ptr = MEM_BASE, starve_cnt = 0.
  - ldr_rvalid = 0, ldr_rd = 0, fault = 0.
  - init_done = 0 if CLEAR_ON_RESET=1, else 1.
- Reset mid-operation: an in-flight clear restarts from MEM_BASE. A loader read accepted in the reset cycle produces no ldr_rvalid.
- CLEAR state:
  - Each cycle: mem_we=1, mem_a=clr_ptr, mem_wd=0; clr_ptr increments.
  - After the cycle that writes MEM_TOP, the block moves to RUN and init_done=1.
  - Clear takes MEM_TOP-MEM_BASE+1 cycles (4096 at defaults).
  - ldr_ready=0 throughout. cpu_stall=cpu_req. cpu_rd=0.
- RUN state, grant (combinational, single winner per cycle):
  - loader wins if ldr_valid && (!cpu_req || starve_cnt==STARVE_LIMIT); otherwise the CPU wins if cpu_req.
  - ldr_ready = loader wins. cpu_stall = cpu_req && !CPU wins.
- starve_cnt:
  - Increments when ldr_valid && cpu_req && the CPU wins.
  - Clears when the loader wins or ldr_valid=0.
  - Saturates at STARVE_LIMIT.
- Memory drive:
  - mem_a = winner's address.
  - mem_we = winner's write enable && in_range.
  - mem_wd = winner's data.
  - With no winner: mem_we=0, mem_a=MEM_BASE.
- Range check:
  - in_range = MEM_BASE <= addr <= MEM_TOP, unsigned.
  - For an out-of-range address, mem_a is forced to MEM_BASE, the write is suppressed, and read data is 0.
  - The request still completes: ldr_ready=1 or cpu_stall=0.
  - fault=1 on the next cycle.
- cpu_rd = mem_rd when the CPU wins and in_range, else 0.
- Loader read: on an accepted read, ldr_rd <= (in_range ? mem_rd : 0) and ldr_rvalid=1 next cycle. An accepted write gives no rvalid.
- Loader handshake: ldr_valid and its payload are held until ldr_ready. Requests may be back-to-back, one per cycle.
- Simultaneous write and read of the same index by different ports cannot occur because there is one winner per cycle.

Test Plan:
- Reset with CLEAR_ON_RESET=1 and memory preloaded with 32'hDEADBEEF -> mem_we high for 4096 cycles, init_done rises after the MEM_TOP write, loader reads of 0x1000 and 0x1FFF return 0.
- cpu_req held during CLEAR -> cpu_stall=1 every cycle, no CPU write lands; in the first RUN cycle cpu_stall=0 and the store of 32'h12345678 to 0x1004 commits.
- Loader write 32'hA5A5A5A5 to 0x1010 then read 0x1010 with no CPU traffic -> ldr_ready on both; one cycle after the read, ldr_rvalid=1 and ldr_rd=32'hA5A5A5A5.
- cpu_req held continuously with ldr_valid held, STARVE_LIMIT=8 -> CPU granted 8 cycles, loader granted on the 9th with cpu_stall=1 for exactly that cycle, then the pattern repeats.
- CPU store to 0x0FFF and loader read of 0x2000 -> mem_we=0, fault pulses one cycle later for each, ldr_rd=0, memory unchanged.
- rst_n asserted for one cycle mid-clear at clr_ptr=0x1800 -> clr_ptr restarts at 0x1000, init_done=0, a pending loader read yields no ldr_rvalid.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bundle of the CPU MEM-stage port, the loader/debug port and the data-memory
// port that dmem_arbiter multiplexes. "slave" is the arbiter's view; "master"
// is the environment (CPU, loader and memory) view.
interface dmem_arbiter_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    // CPU MEM stage
    logic                     cpu_req;
    logic                     cpu_we;
    logic [ADDRESS_WIDTH-1:0] cpu_a;
    logic [DATA_WIDTH-1:0]    cpu_wd;
    logic [DATA_WIDTH-1:0]    cpu_rd;
    logic                     cpu_stall;

    // Loader / debug port
    logic                     ldr_valid;
    logic                     ldr_we;
    logic [ADDRESS_WIDTH-1:0] ldr_a;
    logic [DATA_WIDTH-1:0]    ldr_wd;
    logic                     ldr_ready;
    logic [DATA_WIDTH-1:0]    ldr_rd;
    logic                     ldr_rvalid;

    // Data memory (async read, write on posedge clk)
    logic                     mem_we;
    logic [ADDRESS_WIDTH-1:0] mem_a;
    logic [DATA_WIDTH-1:0]    mem_wd;
    logic [DATA_WIDTH-1:0]    mem_rd;

    modport slave (
        input  cpu_req, cpu_we, cpu_a, cpu_wd,
        output cpu_rd, cpu_stall,
        input  ldr_valid, ldr_we, ldr_a, ldr_wd,
        output ldr_ready, ldr_rd, ldr_rvalid,
        output mem_we, mem_a, mem_wd,
        input  mem_rd
    );

    modport master (
        output cpu_req, cpu_we, cpu_a, cpu_wd,
        input  cpu_rd, cpu_stall,
        output ldr_valid, ldr_we, ldr_a, ldr_wd,
        input  ldr_ready, ldr_rd, ldr_rvalid,
        input  mem_we, mem_a, mem_wd,
        output mem_rd
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: shares one word-addressed memory port between the
// CPU MEM stage and a loader/debug port, zero-fills the memory window after
// reset and bounds-checks every granted access against that window.
module dmem_arbiter #(
    parameter int                       ADDRESS_WIDTH  = 32,
    parameter int                       DATA_WIDTH     = 32,
    parameter logic [ADDRESS_WIDTH-1:0] MEM_BASE       = ADDRESS_WIDTH'(32'h1000),
    parameter logic [ADDRESS_WIDTH-1:0] MEM_TOP        = ADDRESS_WIDTH'(32'h1FFF),
    parameter bit                       CLEAR_ON_RESET = 1'b1,
    parameter int                       STARVE_LIMIT   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    dmem_arbiter_if.slave       bus,
    output logic                init_done,
    output logic                fault
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam state_t         RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
    localparam logic [7:0]     STARVE_MAX  = 8'(STARVE_LIMIT);

    state_t                    state_q, state_d;
    logic [ADDRESS_WIDTH-1:0]  clr_ptr_q, clr_ptr_d;
    logic [7:0]                starve_cnt_q, starve_cnt_d;
    logic [DATA_WIDTH-1:0]     ldr_rd_q, ldr_rd_d;
    logic                      ldr_rvalid_q, ldr_rvalid_d;
    logic                      fault_q, fault_d;

    logic                      run;
    logic                      ldr_win;
    logic                      cpu_win;
    logic                      any_win;
    logic [ADDRESS_WIDTH-1:0]  sel_a;
    logic                      sel_we;
    logic [DATA_WIDTH-1:0]     sel_wd;
    logic                      in_range;

    logic                      mem_we_c;
    logic [ADDRESS_WIDTH-1:0]  mem_a_c;
    logic [DATA_WIDTH-1:0]     mem_wd_c;

    // Single winner per cycle: the loader only beats a requesting CPU once it
    // has watched the CPU win STARVE_LIMIT cycles in a row.
    assign run     = (state_q == ST_RUN);
    assign ldr_win = run && bus.ldr_valid &&
                     (!bus.cpu_req || (starve_cnt_q == STARVE_MAX));
    assign cpu_win = run && bus.cpu_req && !ldr_win;
    assign any_win = ldr_win || cpu_win;

    assign sel_a   = ldr_win ? bus.ldr_a  : bus.cpu_a;
    assign sel_we  = ldr_win ? bus.ldr_we : bus.cpu_we;
    assign sel_wd  = ldr_win ? bus.ldr_wd : bus.cpu_wd;

    assign in_range = (sel_a >= MEM_BASE) && (sel_a <= MEM_TOP);

    // Next-state, clear engine, memory drive and starvation counter.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // can leave one unassigned and infer a latch.
        state_d      = state_q;
        clr_ptr_d    = clr_ptr_q;
        starve_cnt_d = starve_cnt_q;
        mem_we_c     = 1'b0;
        mem_a_c      = MEM_BASE;
        mem_wd_c     = '0;

        unique case (state_q)
            ST_CLEAR: begin
                mem_we_c  = 1'b1;
                mem_a_c   = clr_ptr_q;
                clr_ptr_d = clr_ptr_q + ADDRESS_WIDTH'(1);
                if (clr_ptr_q == MEM_TOP) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                // Out-of-range accesses still complete, but are parked on
                // MEM_BASE with the write suppressed.
                if (any_win) begin
                    mem_a_c  = in_range ? sel_a : MEM_BASE;
                    mem_we_c = sel_we && in_range;
                    mem_wd_c = sel_wd;
                end

                if (ldr_win || !bus.ldr_valid) begin
                    starve_cnt_d = '0;
                end else if (cpu_win && starve_cnt_q != STARVE_MAX) begin
                    starve_cnt_d = starve_cnt_q + 8'd1;
                end
            end
        endcase
    end

    // Loader read capture and out-of-range fault flag for the following cycle.
    always_comb begin
        ldr_rd_d     = ldr_rd_q;
        ldr_rvalid_d = ldr_win && !bus.ldr_we;
        fault_d      = any_win && !in_range;
        if (ldr_win && !bus.ldr_we) begin
            ldr_rd_d = in_range ? bus.mem_rd : '0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!rst_n) begin
            state_q      <= RESET_STATE;
            clr_ptr_q    <= MEM_BASE;
            starve_cnt_q <= '0;
            ldr_rd_q     <= '0;
            ldr_rvalid_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_ptr_q    <= clr_ptr_d;
            starve_cnt_q <= starve_cnt_d;
            ldr_rd_q     <= ldr_rd_d;
            ldr_rvalid_q <= ldr_rvalid_d;
            fault_q      <= fault_d;
        end
    end

    assign bus.mem_we     = mem_we_c;
    assign bus.mem_a      = mem_a_c;
    assign bus.mem_wd     = mem_wd_c;
    assign bus.cpu_rd     = (cpu_win && in_range) ? bus.mem_rd : '0;
    assign bus.cpu_stall  = bus.cpu_req && !cpu_win;
    assign bus.ldr_ready  = ldr_win;
    assign bus.ldr_rd     = ldr_rd_q;
    assign bus.ldr_rvalid = ldr_rvalid_q;
    assign init_done      = run;
    assign fault          = fault_q;

endmodule
